// File: rtl/reg_scan_if.sv
// Handshake bundle between the register-scan sequencer, the register file read
// ports and the display controller.
interface reg_scan_if;
  logic        tick;
  logic        run_btn;
  logic        step_btn;
  logic [15:0] R;
  logic [15:0] S;
  logic [2:0]  r_adr;
  logic [2:0]  s_adr;
  logic [7:0]  disp_r;
  logic [7:0]  disp_s;
  logic        running;
  logic        wrap;

  modport master (
    output tick, run_btn, step_btn, R, S,
    input  r_adr, s_adr, disp_r, disp_s, running, wrap
  );

  modport slave (
    input  tick, run_btn, step_btn, R, S,
    output r_adr, s_adr, disp_r, disp_s, running, wrap
  );
endinterface

// File: rtl/reg_scan_sequencer.sv
// Steps the register file read ports through adjacent register pairs and latches
// their low bytes for display, with run/pause toggle and single-step control.
module reg_scan_sequencer #(
  parameter int unsigned HOLD_TICKS = 500
) (
  input logic       clk,
  input logic       reset,
  reg_scan_if.slave bus
);
  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

  localparam logic [15:0] CNT_LAST = 16'(HOLD_TICKS - 1);

  state_t      state;
  logic        run_q;
  logic        step_q;
  logic        cap_pending;
  logic        wrap;
  logic [15:0] cnt;
  logic [2:0]  r_adr;
  logic [2:0]  s_adr;
  logic [7:0]  disp_r;
  logic [7:0]  disp_s;

  logic run_edge;
  logic step_edge;
  logic dwell_done;
  logic advance;
  logic unused_hi;

  assign run_edge   = bus.run_btn & ~run_q;
  assign step_edge  = bus.step_btn & ~step_q;
  assign dwell_done = (state == RUNNING) && bus.tick && (cnt == CNT_LAST);
  // A run toggle always wins: it suppresses both a step and an expiring dwell.
  assign advance    = !run_edge && ((state == PAUSED) ? step_edge : dwell_done);
  assign unused_hi  = ^{bus.R[15:8], bus.S[15:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PAUSED;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      cap_pending <= 1'b1;
      wrap        <= 1'b0;
      cnt         <= '0;
      r_adr       <= 3'd0;
      s_adr       <= 3'd1;
      disp_r      <= '0;
      disp_s      <= '0;
    end else begin
      run_q  <= bus.run_btn;
      step_q <= bus.step_btn;
      wrap   <= advance && (r_adr == 3'd7);

      // Capture one cycle after the address moved so the combinational read has settled.
      if (cap_pending) begin
        disp_r <= bus.R[7:0];
        disp_s <= bus.S[7:0];
      end
      cap_pending <= advance;

      if (advance) begin
        r_adr <= r_adr + 3'd1;
        s_adr <= r_adr + 3'd2;
      end

      if (run_edge) begin
        state <= (state == PAUSED) ? RUNNING : PAUSED;
        cnt   <= '0;
      end else if ((state == RUNNING) && bus.tick) begin
        cnt <= dwell_done ? 16'd0 : cnt + 16'd1;
      end
    end
  end

  assign bus.r_adr   = r_adr;
  assign bus.s_adr   = s_adr;
  assign bus.disp_r  = disp_r;
  assign bus.disp_s  = disp_s;
  assign bus.running = (state == RUNNING);
  assign bus.wrap    = wrap;
endmodule

// File: doc/reg_scan_sequencer.md
# reg_scan_sequencer

Automatic read-address sequencer between the register file and the display controller. It steps the register file's two read ports through all eight registers as an adjacent pair (R = n, S = n+1 mod 8). It captures the low byte of each read port and holds it for a programmable dwell time. Debounced run/step buttons allow free-running scan, pause and single-step inspection.

## Interface
- HOLD_TICKS, 500: dwell per register pair, counted in `tick` pulses; legal range 1..65535.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- tick  in  1  single-cycle enable pulse (e.g. 500 Hz strobe); ignored while reset is high.
- run_btn  in  1  debounced level; each rising edge toggles RUNNING/PAUSED.
- step_btn  in  1  debounced level; each rising edge advances one pair while PAUSED.
- R  in  16  register file read-port R data; combinational from r_adr.
- S  in  16  register file read-port S data; combinational from s_adr.
- r_adr  out  3  read address R.
- s_adr  out  3  read address S; always r_adr+1 mod 8.
- disp_r  out  8  captured R[7:0], to display high pair.
- disp_s  out  8  captured S[7:0], to display low pair.
- running  out  1  1 in RUNNING, 0 in PAUSED.
- wrap  out  1  one-cycle pulse when r_adr goes 7 -> 0.

## Operation
- States: PAUSED (reset state) and RUNNING. Held in one registered bit, exported as `running`.
- Edge detect: registered copies run_q and step_q. run_edge = run_btn & ~run_q; step_edge = step_btn & ~step_q. Both copies reset to 0, so a button held through reset produces an edge on the first cycle after reset.
- PAUSED:
  - run_edge -> RUNNING and hold counter cleared to 0.
  - step_edge (without run_edge) -> advance.
- RUNNING:
  - run_edge -> PAUSED and counter cleared. No advance in that cycle, even if the dwell expires in the same cycle.
  - Otherwise, on tick: if cnt == HOLD_TICKS-1 then advance and cnt <= 0; else cnt <= cnt+1.
  - step_edge is ignored.
- Priority: run_edge > step_edge. A simultaneous step is dropped, not queued.
- Advance: r_adr <= r_adr+1 (3-bit wrap), s_adr <= r_adr+2 (3-bit wrap), cap_pending <= 1. wrap asserts for that cycle when r_adr was 7.
- Capture: when cap_pending = 1, disp_r <= R[7:0] and disp_s <= S[7:0], then cap_pending <= 0.
  - R and S are sampled one cycle after the address change, so the register file's combinational read settles.
  - An advance in the same cycle as a capture is legal: the capture uses current data, and cap_pending remains 1 for the new address.
- Counter: 16 bits. Only increments on tick in RUNNING, so it never exceeds HOLD_TICKS-1.

## Timing
- Reset values:
  - r_adr = 0, s_adr = 1
  - disp_r = 0, disp_s = 0
  - running = 0, wrap = 0
  - cnt = 0, run_q = 0, step_q = 0
  - cap_pending = 1: the pair at address 0/1 is captured on the first edge after reset deasserts.
- Reset asserted mid-dwell or mid-capture: all registers return to reset values on that edge. No partial capture.
- Button edge to state change: button sampled high at edge k -> running toggles, or r_adr advances, at edge k (registered).
- Address change to display: r_adr updates at edge k. disp_r/disp_s hold the new data after edge k+1 (latency 1 cycle after address).
- Dwell in RUNNING is exactly HOLD_TICKS tick pulses between advances. The first advance after entering RUNNING comes HOLD_TICKS ticks after the toggle edge.
- wrap is high for exactly one clk cycle, coincident with r_adr = 0 appearing.
- HOLD_TICKS = 1: every tick in RUNNING advances.

## Test plan
- Reset release with R=16'h00AA at adr 0, S=16'h00BB at adr 1:
  - one cycle later, disp_r=8'hAA, disp_s=8'hBB, running=0, r_adr=0, s_adr=1.
- PAUSED, 3 step_btn pulses (each held 4 cycles):
  - r_adr=3, s_adr=4; disp shows regs 3/4 one cycle after each advance; no extra advances while the button stays high.
- HOLD_TICKS=3, run edge, then 9 ticks:
  - advances after ticks 3, 6 and 9; r_adr=3; running=1.
- RUNNING from r_adr=7, dwell expires:
  - r_adr=0, s_adr=1; wrap high for exactly one cycle.
- run_edge and dwell-expiring tick in the same cycle:
  - running=0, r_adr unchanged, cnt=0.
- run_edge and step_edge in the same cycle while PAUSED:
  - running=1, r_adr unchanged.
- Reset asserted during RUNNING at r_adr=5:
  - next edge r_adr=0, running=0; capture of 0/1 follows.
